// File: rtl/apb_i2c_fifo_bridge.sv
// APB register bank with TX/RX FIFOs, read sequencer and interrupt for an I2C master engine.
// Optional: APB_I2C_FIFO_ERR_SLVERR_EN reports TX-full writes and RX-empty reads via pslverr.
module apb_i2c_fifo_bridge #(
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [31:0]           paddr,
    input  logic [2:0]            pprot,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [3:0]            pstrb,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr,
    output logic [7:0]            addr_r_w,
    input  logic                  read_fifo_tx,
    output logic [FIFO_WIDTH-1:0] tx_data,
    output logic                  tx_empty,
    input  logic                  write_fifo_rx,
    input  logic [FIFO_WIDTH-1:0] rx_data_in,
    output logic                  rx_full,
    output logic                  end_rx,
    output logic                  irq
);

    localparam int unsigned PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = PW + 1;

    localparam logic [2:0] REG_CTRL       = 3'd0;
    localparam logic [2:0] REG_STATUS     = 3'd1;
    localparam logic [2:0] REG_TX_DATA    = 3'd2;
    localparam logic [2:0] REG_RX_DATA    = 3'd3;
    localparam logic [2:0] REG_THRESH     = 3'd4;
    localparam logic [2:0] REG_N_READS    = 3'd5;
    localparam logic [2:0] REG_I2C_ADDR   = 3'd6;
    localparam logic [2:0] REG_IRQ_STATUS = 3'd7;

    logic [3:0]            irq_en_q;
    logic [7:0]            tx_low_thr_q;
    logic [7:0]            rx_high_thr_q;
    logic [8:0]            remaining_q;
    logic [7:0]            addr_q;
    logic [5:0]            irq_status_q;
    logic                  irq_q;

    logic [PW-1:0]         tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    logic [LW-1:0]         tx_level_q, rx_level_q;
    logic [FIFO_WIDTH-1:0] tx_mem [DEPTH];
    logic [FIFO_WIDTH-1:0] rx_mem [DEPTH];

    logic [31:0]           offset;
    logic [2:0]            sel;
    logic                  access, in_range, wr, rd, err_cond;
    logic                  valid_wr, valid_rd;
    logic                  tx_wr_try, rx_rd_try;
    logic                  tx_full, rx_empty;
    logic                  tx_push, tx_pop, rx_push, rx_pop;
    logic                  tx_flush, rx_flush;
    logic                  ctrl_wr, thresh_wr, nreads_wr, addr_wr, w1c_wr;
    logic [5:0]            set_vec, en_vec;
    logic [5:0]            irq_status_d;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  unused_bits;

    assign unused_bits = ^{pprot, pstrb, pwdata};

    // Address decode
    assign offset   = paddr - 32'(BASE_ADDR);
    assign in_range = (paddr >= 32'(BASE_ADDR)) && (offset <= 32'h1C);
    assign sel      = offset[4:2];
    assign access   = psel & penable;
    assign wr       = access & in_range & pwrite;
    assign rd       = access & in_range & ~pwrite;

    assign tx_full  = (tx_level_q == LW'(DEPTH));
    assign tx_empty = (tx_level_q == '0);
    assign rx_full  = (rx_level_q == LW'(DEPTH));
    assign rx_empty = (rx_level_q == '0);

    assign tx_wr_try = wr & (sel == REG_TX_DATA);
    assign rx_rd_try = rd & (sel == REG_RX_DATA);

`ifdef APB_I2C_FIFO_ERR_SLVERR_EN
    assign err_cond = (tx_wr_try & tx_full) | (rx_rd_try & rx_empty);
`else
    assign err_cond = 1'b0;
`endif

    assign pready   = access;
    assign pslverr  = access & (~in_range | err_cond);
    assign valid_wr = wr & ~err_cond;
    assign valid_rd = rd & ~err_cond;

    assign ctrl_wr   = valid_wr & (sel == REG_CTRL);
    assign thresh_wr = valid_wr & (sel == REG_THRESH);
    assign nreads_wr = valid_wr & (sel == REG_N_READS);
    assign addr_wr   = valid_wr & (sel == REG_I2C_ADDR);
    assign w1c_wr    = valid_wr & (sel == REG_IRQ_STATUS);
    assign tx_flush  = ctrl_wr & pwdata[0];
    assign rx_flush  = ctrl_wr & pwdata[1];

    // Full/empty are sampled before the update, so each side resolves independently.
    assign tx_push = tx_wr_try & ~tx_full;
    assign tx_pop  = read_fifo_tx & ~tx_empty;
    assign rx_push = write_fifo_rx & ~rx_full;
    assign rx_pop  = rx_rd_try & ~rx_empty;

    assign tx_data  = tx_mem[tx_rd_q];
    assign addr_r_w = addr_q;
    assign end_rx   = (remaining_q == '0);
    assign irq      = irq_q;
    assign prdata   = rdata;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tx_mem[i] <= '0;
            end
        end else if (tx_push) begin
            tx_mem[tx_wr_q] <= pwdata[FIFO_WIDTH-1:0];
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rx_mem[i] <= '0;
            end
        end else if (rx_push) begin
            rx_mem[rx_wr_q] <= rx_data_in;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_level_q <= '0;
        end else if (tx_flush) begin
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_level_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + PW'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + PW'(1);
            tx_level_q <= tx_level_q + LW'(tx_push) - LW'(tx_pop);
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_level_q <= '0;
        end else if (rx_flush) begin
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_level_q <= '0;
        end else begin
            if (rx_push) rx_wr_q <= rx_wr_q + PW'(1);
            if (rx_pop)  rx_rd_q <= rx_rd_q + PW'(1);
            rx_level_q <= rx_level_q + LW'(rx_push) - LW'(rx_pop);
        end
    end

    // Every engine push counts against the read budget, even one dropped on overflow.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            remaining_q <= '0;
        end else if (nreads_wr) begin
            remaining_q <= pwdata[8:0];
        end else if (write_fifo_rx && (remaining_q != '0)) begin
            remaining_q <= remaining_q - 9'd1;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            irq_en_q      <= '0;
            tx_low_thr_q  <= '0;
            rx_high_thr_q <= '0;
            addr_q        <= '0;
        end else begin
            if (ctrl_wr)   irq_en_q <= pwdata[5:2];
            if (thresh_wr) {rx_high_thr_q, tx_low_thr_q} <= pwdata[15:0];
            if (addr_wr)   addr_q <= pwdata[7:0];
        end
    end

    always_comb begin
        set_vec    = '0;
        set_vec[0] = (9'(tx_level_q) <= {1'b0, tx_low_thr_q});
        set_vec[1] = (rx_high_thr_q != '0) && (9'(rx_level_q) >= {1'b0, rx_high_thr_q});
        set_vec[2] = write_fifo_rx && (remaining_q == 9'd1) && !nreads_wr;
        set_vec[3] = tx_wr_try & tx_full;
        set_vec[4] = write_fifo_rx & rx_full;
        set_vec[5] = rx_rd_try & rx_empty;
        en_vec     = {irq_en_q[3], irq_en_q[3], irq_en_q[3], irq_en_q[2:0]};
        // Set wins over a same-cycle clear.
        irq_status_d = (irq_status_q & ~(w1c_wr ? pwdata[5:0] : 6'd0)) | set_vec;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            irq_status_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            irq_status_q <= irq_status_d;
            irq_q        <= |(irq_status_q & en_vec);
        end
    end

    always_comb begin
        rdata = '0;
        if (valid_rd) begin
            case (sel)
                REG_CTRL:       rdata[5:2] = irq_en_q;
                REG_STATUS: begin
                    rdata[8:0]  = 9'(tx_level_q);
                    rdata[17:9] = 9'(rx_level_q);
                    rdata[18]   = tx_full;
                    rdata[19]   = tx_empty;
                    rdata[20]   = rx_full;
                    rdata[21]   = rx_empty;
                    rdata[22]   = end_rx;
                end
                REG_RX_DATA: begin
                    if (!rx_empty) rdata = DATA_WIDTH'(rx_mem[rx_rd_q]);
                end
                REG_THRESH:     rdata[15:0] = {rx_high_thr_q, tx_low_thr_q};
                REG_N_READS:    rdata[8:0] = remaining_q;
                REG_I2C_ADDR:   rdata[7:0] = addr_q;
                REG_IRQ_STATUS: rdata[5:0] = irq_status_q;
                default:        rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_i2c_fifo_bridge.sv
// Scoreboard bench for apb_i2c_fifo_bridge: FIFO data order, levels, sequencer, flags and decode.
`timescale 1ns/1ps
module tb_apb_i2c_fifo_bridge;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned FW    = 8;
    localparam logic [31:0] BASE  = 32'h0000_0040;

    localparam logic [31:0] A_CTRL   = BASE + 32'h00;
    localparam logic [31:0] A_STATUS = BASE + 32'h04;
    localparam logic [31:0] A_TXD    = BASE + 32'h08;
    localparam logic [31:0] A_RXD    = BASE + 32'h0C;
    localparam logic [31:0] A_THRESH = BASE + 32'h10;
    localparam logic [31:0] A_NREADS = BASE + 32'h14;
    localparam logic [31:0] A_I2CA   = BASE + 32'h18;
    localparam logic [31:0] A_IRQST  = BASE + 32'h1C;

`ifdef APB_I2C_FIFO_ERR_SLVERR_EN
    localparam logic SlvErrEn = 1'b1;
`else
    localparam logic SlvErrEn = 1'b0;
`endif

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic [31:0]   paddr = '0;
    logic [2:0]    pprot = '0;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0]   pwdata = '0;
    logic [3:0]    pstrb = 4'hF;
    logic          pready, pslverr;
    logic [31:0]   prdata;
    logic [7:0]    addr_r_w;
    logic          read_fifo_tx = 1'b0;
    logic [FW-1:0] tx_data;
    logic          tx_empty;
    logic          write_fifo_rx = 1'b0;
    logic [FW-1:0] rx_data_in = '0;
    logic          rx_full, end_rx, irq;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [31:0] rd_v;
    logic        err_v;
    logic [7:0]  exp_b;

    apb_i2c_fifo_bridge #(
        .BASE_ADDR (BASE),
        .DATA_WIDTH(32),
        .FIFO_WIDTH(FW),
        .DEPTH     (DEPTH)
    ) dut (
        .pclk         (pclk),
        .presetn      (presetn),
        .paddr        (paddr),
        .pprot        (pprot),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .pwdata       (pwdata),
        .pstrb        (pstrb),
        .pready       (pready),
        .prdata       (prdata),
        .pslverr      (pslverr),
        .addr_r_w     (addr_r_w),
        .read_fifo_tx (read_fifo_tx),
        .tx_data      (tx_data),
        .tx_empty     (tx_empty),
        .write_fifo_rx(write_fifo_rx),
        .rx_data_in   (rx_data_in),
        .rx_full      (rx_full),
        .end_rx       (end_rx),
        .irq          (irq)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input int txl, input int rxl, input logic endr);
        logic [31:0] s;
        s       = '0;
        s[8:0]  = 9'(txl);
        s[17:9] = 9'(rxl);
        s[18]   = (txl == DEPTH);
        s[19]   = (txl == 0);
        s[20]   = (rxl == DEPTH);
        s[21]   = (rxl == 0);
        s[22]   = endr;
        return s;
    endfunction

    // One APB transfer; optional engine strobes ride along in the access phase.
    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic pop_tx, input logic push_rx, input logic [7:0] rx_byte,
                       output logic [31:0] rdata, output logic err);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(negedge pclk);
        penable = 1'b1; read_fifo_tx = pop_tx; write_fifo_rx = push_rx; rx_data_in = rx_byte;
        #1;
        rdata = prdata;
        err   = pslverr;
        check("pready", {31'd0, pready}, 32'd1);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; read_fifo_tx = 1'b0; write_fifo_rx = 1'b0;
    endtask

    task automatic reg_wr(input string tag, input logic [31:0] addr, input logic [31:0] d,
                          input logic exp_err);
        logic [31:0] r;
        logic e;
        apb(1'b1, addr, d, 1'b0, 1'b0, 8'h00, r, e);
        check({tag, "_slverr"}, {31'd0, e}, {31'd0, exp_err});
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        logic e;
        apb(1'b0, addr, 32'd0, 1'b0, 1'b0, 8'h00, r, e);
        check(tag, r, exp);
        check({tag, "_slverr"}, {31'd0, e}, 32'd0);
    endtask

    task automatic rx_pop_chk(input string tag);
        logic [31:0] r;
        logic e;
        logic [7:0] b;
        b = rx_q.pop_front();
        apb(1'b0, A_RXD, 32'd0, 1'b0, 1'b0, 8'h00, r, e);
        check(tag, r, {24'd0, b});
    endtask

    task automatic tx_pop_chk(input string tag);
        logic [7:0] b;
        b = tx_q.pop_front();
        @(negedge pclk);
        check(tag, {24'd0, tx_data}, {24'd0, b});
        read_fifo_tx = 1'b1;
        @(negedge pclk);
        read_fifo_tx = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        @(negedge pclk);
        write_fifo_rx = 1'b1; rx_data_in = b;
        if (rx_q.size() < DEPTH) rx_q.push_back(b);
        @(negedge pclk);
        write_fifo_rx = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);

        // Reset state
        check("rst_tx_empty", {31'd0, tx_empty}, 32'd1);
        check("rst_end_rx", {31'd0, end_rx}, 32'd1);
        check("rst_rx_full", {31'd0, rx_full}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_addr", {24'd0, addr_r_w}, 32'd0);
        rd_chk("rst_status", A_STATUS, exp_status(0, 0, 1'b1));
        rd_chk("rst_ctrl", A_CTRL, 32'd0);
        rd_chk("rst_thresh", A_THRESH, 32'd0);
        rd_chk("rst_irqst", A_IRQST, 32'h01);

        // Fill TX past full
        for (int i = 1; i <= 17; i++) begin
            reg_wr("tx_fill", A_TXD, 32'(i), SlvErrEn & (tx_q.size() == DEPTH));
            if (tx_q.size() < DEPTH) tx_q.push_back(8'(i));
        end
        rd_chk("tx_full_status", A_STATUS, exp_status(16, 0, 1'b1));
        check("tx_full_pin_empty", {31'd0, tx_empty}, 32'd0);
        rd_chk("tx_ovf_irqst", A_IRQST, 32'h09);
        reg_wr("w1c_all", A_IRQST, 32'h3F, 1'b0);
        rd_chk("w1c_cleared", A_IRQST, 32'h00);

        // Simultaneous pop and push while full
        @(negedge pclk);
        check("tx_head", {24'd0, tx_data}, {24'd0, tx_q[0]});
        void'(tx_q.pop_front());
        apb(1'b1, A_TXD, 32'h99, 1'b1, 1'b0, 8'h00, rd_v, err_v);
        check("tx_simul_slverr", {31'd0, err_v}, {31'd0, SlvErrEn});
        rd_chk("tx_simul_status", A_STATUS, exp_status(15, 0, 1'b1));
        rd_chk("tx_simul_irqst", A_IRQST, 32'h08);

        // Drain TX; the rejected 0x99 must never show up
        while (tx_q.size() > 0) tx_pop_chk("tx_data");
        @(negedge pclk);
        check("tx_drained_empty", {31'd0, tx_empty}, 32'd1);
        rd_chk("tx_drained_status", A_STATUS, exp_status(0, 0, 1'b1));

        // Read sequencer with rx_done interrupt
        reg_wr("ctrl_rxdone", A_CTRL, 32'h10, 1'b0);
        reg_wr("nreads3", A_NREADS, 32'd3, 1'b0);
        check("end_rx_loaded", {31'd0, end_rx}, 32'd0);
        rd_chk("nreads_rb", A_NREADS, 32'd3);
        reg_wr("w1c_all2", A_IRQST, 32'h3F, 1'b0);
        rx_push(8'hA5);
        rx_push(8'h5A);
        check("end_rx_mid", {31'd0, end_rx}, 32'd0);
        rd_chk("nreads_rem1", A_NREADS, 32'd1);
        @(negedge pclk);
        write_fifo_rx = 1'b1; rx_data_in = 8'h3C; rx_q.push_back(8'h3C);
        @(negedge pclk);
        write_fifo_rx = 1'b0;
        check("end_rx_done", {31'd0, end_rx}, 32'd1);
        check("irq_latency", {31'd0, irq}, 32'd0);
        @(negedge pclk);
        check("irq_rx_done", {31'd0, irq}, 32'd1);
        rd_chk("irqst_rx_done", A_IRQST, 32'h05);
        reg_wr("w1c_rxdone", A_IRQST, 32'h04, 1'b0);
        @(negedge pclk);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        rd_chk("rx3_status", A_STATUS, exp_status(0, 3, 1'b1));
        for (int i = 0; i < 3; i++) rx_pop_chk("rx_data");

        // Count truncation and abort
        reg_wr("nreads_trunc", A_NREADS, 32'h201, 1'b0);
        rd_chk("nreads_trunc_rb", A_NREADS, 32'd1);
        reg_wr("nreads_abort", A_NREADS, 32'd0, 1'b0);
        rd_chk("abort_no_done", A_IRQST, 32'h01);
        check("abort_end_rx", {31'd0, end_rx}, 32'd1);

        // RX flush wins over a same-cycle push
        for (int i = 0; i < 5; i++) rx_push(8'(8'h10 + i));
        rd_chk("rx5_status", A_STATUS, exp_status(0, 5, 1'b1));
        apb(1'b1, A_CTRL, 32'h2, 1'b0, 1'b1, 8'h77, rd_v, err_v);
        rx_q.delete();
        rd_chk("rx_flush_status", A_STATUS, exp_status(0, 0, 1'b1));
        check("rx_flush_full", {31'd0, rx_full}, 32'd0);
        rd_chk("rx_flush_irqst", A_IRQST, 32'h01);

        // Address decode
        reg_wr("i2ca", A_I2CA, 32'hA1, 1'b0);
        check("addr_r_w", {24'd0, addr_r_w}, 32'hA1);
        reg_wr("ctrl_rxhigh", A_CTRL, 32'h08, 1'b0);
        reg_wr("bad_wr_hi", BASE + 32'h20, 32'h3F, 1'b1);
        reg_wr("bad_wr_lo", BASE - 32'h04, 32'h3F, 1'b1);
        reg_wr("bad_wr_i2c", BASE + 32'h38, 32'h55, 1'b1);
        rd_chk("ctrl_kept", A_CTRL, 32'h08);
        rd_chk("i2ca_kept", A_I2CA, 32'hA1);
        check("addr_kept", {24'd0, addr_r_w}, 32'hA1);
        apb(1'b0, BASE + 32'h38, 32'd0, 1'b0, 1'b0, 8'h00, rd_v, err_v);
        check("bad_rd_data", rd_v, 32'd0);
        check("bad_rd_slverr", {31'd0, err_v}, 32'd1);

        // RX high threshold
        reg_wr("thresh", A_THRESH, 32'h0200, 1'b0);
        rd_chk("thresh_rb", A_THRESH, 32'h0200);
        rx_push(8'h11);
        rd_chk("rxhigh_below", A_IRQST, 32'h01);
        check("irq_below", {31'd0, irq}, 32'd0);
        rx_push(8'h22);
        repeat (2) @(negedge pclk);
        check("irq_rxhigh", {31'd0, irq}, 32'd1);
        rd_chk("rxhigh_irqst", A_IRQST, 32'h03);
        while (rx_q.size() > 0) rx_pop_chk("rx_data_thr");
        reg_wr("w1c_rxhigh", A_IRQST, 32'h02, 1'b0);
        rd_chk("rxhigh_cleared", A_IRQST, 32'h01);

        // RX overflow
        reg_wr("thresh0", A_THRESH, 32'h0, 1'b0);
        reg_wr("w1c_all3", A_IRQST, 32'h3F, 1'b0);
        for (int i = 0; i < 17; i++) rx_push(8'(8'hC0 + i));
        @(negedge pclk);
        check("rx_full_pin", {31'd0, rx_full}, 32'd1);
        rd_chk("rx_full_status", A_STATUS, exp_status(0, 16, 1'b1));
        rd_chk("rx_ovf_irqst", A_IRQST, 32'h11);
        while (rx_q.size() > 0) rx_pop_chk("rx_data_ovf");

        // RX underflow
        reg_wr("w1c_all4", A_IRQST, 32'h3F, 1'b0);
        apb(1'b0, A_RXD, 32'd0, 1'b0, 1'b0, 8'h00, rd_v, err_v);
        check("rx_udf_data", rd_v, 32'd0);
        check("rx_udf_slverr", {31'd0, err_v}, {31'd0, SlvErrEn});
        rd_chk("rx_udf_irqst", A_IRQST, 32'h21);
        rd_chk("rx_udf_status", A_STATUS, exp_status(0, 0, 1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
